// File: rtl/apb_timer_array.sv
// apb_timer_array: an array of independent APB-programmable timer channels.
// Each channel has a prescaler, an up-counter with compare, a sticky pending
// flag and a level interrupt. The register file is a zero-wait-state APB slave.
module apb_timer_array #(
  parameter int NumChannels = 4,
  parameter int CntWidth    = 32,
  parameter int PrescWidth  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [31:0]            paddr_i,
  input  logic [31:0]            pwdata_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic [NumChannels-1:0] irq_o
);

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegCount  = 2'd1;
  localparam logic [1:0] RegCmp    = 2'd2;
  localparam logic [1:0] RegStatus = 2'd3;

  localparam logic [CntWidth-1:0]   CntOne   = CntWidth'(1);
  localparam logic [PrescWidth-1:0] PrescOne = PrescWidth'(1);

  // Packs the CTRL fields into their read-back positions; unused bits are 0.
  function automatic logic [31:0] ctrl_word(input logic en, input logic mode,
                                            input logic irq_en,
                                            input logic [PrescWidth-1:0] presc);
    logic [31:0] w;
    w = 32'd0;
    w[0] = en;
    w[1] = mode;
    w[2] = irq_en;
    w[8 +: PrescWidth] = presc;
    return w;
  endfunction

  // Per-channel state.
  logic [NumChannels-1:0] en_q, en_d;
  logic [NumChannels-1:0] mode_q, mode_d;
  logic [NumChannels-1:0] irq_en_q, irq_en_d;
  logic [NumChannels-1:0] pend_q, pend_d;
  logic [NumChannels-1:0] irq_q, irq_d;
  logic [PrescWidth-1:0]  presc_q [NumChannels];
  logic [PrescWidth-1:0]  presc_d [NumChannels];
  logic [PrescWidth-1:0]  pcnt_q  [NumChannels];
  logic [PrescWidth-1:0]  pcnt_d  [NumChannels];
  logic [CntWidth-1:0]    count_q [NumChannels];
  logic [CntWidth-1:0]    count_d [NumChannels];
  logic [CntWidth-1:0]    cmp_q   [NumChannels];
  logic [CntWidth-1:0]    cmp_d   [NumChannels];

  // Address decode: channel in [11:4], register in [3:2], [1:0] must be 0.
  logic [7:0] ch_idx_s;
  logic [1:0] reg_sel_s;
  logic       addr_err_s;
  logic       access_s;
  logic       wr_ok_s;
  logic       rd_ok_s;
  logic       unused_s;

  assign ch_idx_s   = paddr_i[11:4];
  assign reg_sel_s  = paddr_i[3:2];
  assign addr_err_s = (ch_idx_s >= 8'(NumChannels)) || (paddr_i[1:0] != 2'd0);
  assign access_s   = psel_i & penable_i;
  assign wr_ok_s    = access_s & pwrite_i & ~addr_err_s;
  assign rd_ok_s    = psel_i & ~pwrite_i & ~addr_err_s;
  assign pslverr_o  = access_s & addr_err_s;
  assign pready_o   = 1'b1;
  assign irq_o      = irq_q;
  assign unused_s   = ^{paddr_i[31:12], pwdata_i};

  logic [NumChannels-1:0] sel_s, tick_s, match_s;
  logic [NumChannels-1:0] ctrl_wr_s, cnt_wr_s, cmp_wr_s, st_wr_s;

  // Next-state logic: prescaler, counter, compare match, pending and enable.
  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      sel_s[c]     = wr_ok_s && (ch_idx_s == 8'(c));
      ctrl_wr_s[c] = sel_s[c] && (reg_sel_s == RegCtrl);
      cnt_wr_s[c]  = sel_s[c] && (reg_sel_s == RegCount);
      cmp_wr_s[c]  = sel_s[c] && (reg_sel_s == RegCmp);
      st_wr_s[c]   = sel_s[c] && (reg_sel_s == RegStatus);
      tick_s[c]    = en_q[c] && (pcnt_q[c] == presc_q[c]);
      // A COUNT write in the tick cycle suppresses both increment and match.
      match_s[c]   = tick_s[c] && !cnt_wr_s[c] && (count_q[c] == cmp_q[c]);

      if (ctrl_wr_s[c]) begin
        mode_d[c]   = pwdata_i[1];
        irq_en_d[c] = pwdata_i[2];
        presc_d[c]  = pwdata_i[8 +: PrescWidth];
      end else begin
        mode_d[c]   = mode_q[c];
        irq_en_d[c] = irq_en_q[c];
        presc_d[c]  = presc_q[c];
      end

      // A CTRL write always wins over the one-shot auto-clear.
      if (ctrl_wr_s[c]) begin
        en_d[c] = pwdata_i[0];
      end else if (match_s[c] && mode_q[c]) begin
        en_d[c] = 1'b0;
      end else begin
        en_d[c] = en_q[c];
      end

      // Enabling from idle restarts the prescaler phase.
      if (ctrl_wr_s[c] && !en_q[c] && pwdata_i[0]) begin
        pcnt_d[c] = {PrescWidth{1'b0}};
      end else if (tick_s[c]) begin
        pcnt_d[c] = {PrescWidth{1'b0}};
      end else if (en_q[c]) begin
        pcnt_d[c] = pcnt_q[c] + PrescOne;
      end else begin
        pcnt_d[c] = pcnt_q[c];
      end

      if (cnt_wr_s[c]) begin
        count_d[c] = pwdata_i[CntWidth-1:0];
      end else if (match_s[c]) begin
        count_d[c] = {CntWidth{1'b0}};
      end else if (tick_s[c]) begin
        count_d[c] = count_q[c] + CntOne;
      end else begin
        count_d[c] = count_q[c];
      end

      if (cmp_wr_s[c]) begin
        cmp_d[c] = pwdata_i[CntWidth-1:0];
      end else begin
        cmp_d[c] = cmp_q[c];
      end

      // A match set in the same cycle as a W1C keeps PEND set.
      if (match_s[c]) begin
        pend_d[c] = 1'b1;
      end else if (st_wr_s[c] && pwdata_i[0]) begin
        pend_d[c] = 1'b0;
      end else begin
        pend_d[c] = pend_q[c];
      end

      irq_d[c] = pend_d[c] & irq_en_d[c];
    end
  end

  logic [31:0] prdata_s;
  logic [31:0] rd_word_s;

  // Read mux: OR together the word of the single addressed channel.
  always_comb begin
    prdata_s  = 32'd0;
    rd_word_s = 32'd0;
    for (int c = 0; c < NumChannels; c++) begin
      case (reg_sel_s)
        RegCtrl:   rd_word_s = ctrl_word(en_q[c], mode_q[c], irq_en_q[c], presc_q[c]);
        RegCount:  rd_word_s = 32'(count_q[c]);
        RegCmp:    rd_word_s = 32'(cmp_q[c]);
        RegStatus: rd_word_s = {31'd0, pend_q[c]};
        default:   rd_word_s = 32'd0;
      endcase
      prdata_s = prdata_s | ((rd_ok_s && (ch_idx_s == 8'(c))) ? rd_word_s : 32'd0);
    end
  end

  assign prdata_o = prdata_s;

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q     <= {NumChannels{1'b0}};
      mode_q   <= {NumChannels{1'b0}};
      irq_en_q <= {NumChannels{1'b0}};
      pend_q   <= {NumChannels{1'b0}};
      irq_q    <= {NumChannels{1'b0}};
      for (int c = 0; c < NumChannels; c++) begin
        presc_q[c] <= {PrescWidth{1'b0}};
        pcnt_q[c]  <= {PrescWidth{1'b0}};
        count_q[c] <= {CntWidth{1'b0}};
        cmp_q[c]   <= {CntWidth{1'b0}};
      end
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
      for (int c = 0; c < NumChannels; c++) begin
        presc_q[c] <= presc_d[c];
        pcnt_q[c]  <= pcnt_d[c];
        count_q[c] <= count_d[c];
        cmp_q[c]   <= cmp_d[c];
      end
    end
  end

endmodule

// File: tb/tb_apb_timer_array.sv
// Self-checking bench for apb_timer_array (4 channels, 8-bit counters).
// Read expectations are queued when a read is issued and compared when the
// access phase presents data.
module tb_apb_timer_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic [3:0]  irq;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int c0, cd, cw;
  logic [32:0] exp_q [$];

  apb_timer_array #(.NumChannels(4), .CntWidth(8), .PrescWidth(8)) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Edge counter used to derive expected counter values.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Write; commit edge is the edge just before return (cyc holds its index).
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_eq($sformatf("wr_err_%0h", a), pslverr, err);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Read; data is sampled after edge cyc+2 (cyc taken at call time).
  task automatic apb_read(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
    logic [32:0] e;
    exp_q.push_back({exp_e, exp_d});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq(tag, prdata, e[31:0]);
    check_eq({tag, "_err"}, pslverr, e[32]);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_irq", irq, 4'd0);
    check_eq("rst_prdata", prdata, 32'd0);
    check_eq("rst_slverr", pslverr, 1'b0);
    check_eq("rst_pready", pready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    apb_read("rst_ctrl0", 32'h00, 32'd0, 1'b0);
    apb_read("rst_cnt1", 32'h14, 32'd0, 1'b0);
    apb_read("rst_cmp3", 32'h38, 32'd0, 1'b0);

    // Periodic channel 0, compare 3, prescaler 0.
    apb_write(32'h08, 32'd3, 1'b0);
    apb_write(32'h00, 32'h5, 1'b0);
    c0 = cyc;
    apb_read("p_cnt_a", 32'h04, (cyc + 2 - c0) % 4, 1'b0);
    check_eq("p_irq_pre", irq[0], (cyc - c0) >= 4);
    @(posedge clk); #1;
    check_eq("p_irq_rise", irq[0], (cyc - c0) >= 4);
    apb_read("p_cnt_b", 32'h04, (cyc + 2 - c0) % 4, 1'b0);
    apb_read("p_status", 32'h0C, 32'd1, 1'b0);
    apb_write(32'h00, 32'h4, 1'b0);
    cd = cyc;
    check_eq("p_irq_hold", irq[0], 1'b1);
    apb_read("p_cnt_hold1", 32'h04, (cd - c0) % 4, 1'b0);
    apb_read("p_cnt_hold2", 32'h04, (cd - c0) % 4, 1'b0);
    apb_write(32'h0C, 32'h1, 1'b0);
    check_eq("p_irq_w1c", irq[0], 1'b0);
    apb_read("p_status_clr", 32'h0C, 32'd0, 1'b0);

    // One-shot channel 1, compare 2, prescaler 1.
    apb_write(32'h18, 32'd2, 1'b0);
    apb_write(32'h10, 32'h107, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("os_irq_%0d", k), irq[1], k == 6);
    end
    apb_read("os_ctrl", 32'h10, 32'h106, 1'b0);
    apb_read("os_cnt", 32'h14, 32'd0, 1'b0);
    apb_read("os_cnt2", 32'h14, 32'd0, 1'b0);
    apb_write(32'h1C, 32'h1, 1'b0);
    check_eq("os_irq_clr", irq[1], 1'b0);

    // Undecoded accesses.
    apb_read("err_ch4", 32'h40, 32'd0, 1'b1);
    apb_read("err_unal", 32'h06, 32'd0, 1'b1);
    apb_write(32'h0A, 32'hAA, 1'b1);
    apb_read("err_cmp_keep", 32'h08, 32'd3, 1'b0);
    apb_write(32'h40, 32'hFFFF_FFFF, 1'b1);
    apb_read("err_ctrl_keep", 32'h00, 32'h4, 1'b0);

    // Wrap on channel 2: 0xFF -> 0x00 without a compare match.
    apb_write(32'h28, 32'h10, 1'b0);
    apb_write(32'h24, 32'hFF, 1'b0);
    apb_write(32'h20, 32'h5, 1'b0);
    cw = cyc;
    apb_read("wrap_cnt", 32'h24, (cyc + 2 - cw - 1) & 32'hFF, 1'b0);
    apb_read("wrap_pend", 32'h2C, 32'd0, 1'b0);
    check_eq("wrap_irq", irq[2], 1'b0);
    apb_write(32'h20, 32'h0, 1'b0);

    // COUNT write on a tick cycle loads without increment.
    apb_write(32'h38, 32'hF0, 1'b0);
    apb_write(32'h30, 32'h1, 1'b0);
    apb_write(32'h34, 32'h20, 1'b0);
    cw = cyc;
    apb_read("col_cnt", 32'h34, 32'h20 + (cyc + 2 - cw), 1'b0);
    apb_write(32'h30, 32'h0, 1'b0);

    // W1C committed on a match edge: PEND stays set.
    apb_write(32'h04, 32'h0, 1'b0);
    apb_write(32'h00, 32'h5, 1'b0);
    c0 = cyc;
    for (int g = 0; g < 8 && ((cyc + 3 - c0) % 4) != 0; g++) begin
      @(posedge clk); #1;
    end
    apb_write(32'h0C, 32'h1, 1'b0);
    check_eq("col_w1c_irq", irq[0], 1'b1);
    apb_read("col_w1c_pend", 32'h0C, 32'd1, 1'b0);

    // Reset while channel 0 is counting with PEND set.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mrst_irq", irq, 4'd0);
    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 4; r++) begin
        apb_read($sformatf("mrst_c%0d_r%0d", ch, r), 32'(ch * 16 + r * 4), 32'd0, 1'b0);
      end
    end
    check_eq("mrst_irq_after", irq, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_timer_array.md
APB_TIMER_ARRAY -- requirements
Module: apb_timer_array

Interface
REQ-001 SHALL have parameter NumChannels, default 4, number of independent timer channels (1..16).
REQ-002 SHALL have parameter CntWidth, default 32, counter/compare width (1..32).
REQ-003 SHALL have parameter PrescWidth, default 8, prescaler width (1..8).
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port psel_i  input  1  APB select.
REQ-007 SHALL have port penable_i  input  1  APB enable (access phase).
REQ-008 SHALL have port pwrite_i  input  1  APB write=1/read=0.
REQ-009 SHALL have port paddr_i  input  32  APB byte address; bits [11:0] decoded.
REQ-010 SHALL have port pwdata_i  input  32  APB write data.
REQ-011 SHALL have port prdata_o  output  32  APB read data.
REQ-012 SHALL have port pready_o  output  1  APB ready; tied 1 (zero wait states).
REQ-013 SHALL have port pslverr_o  output  1  APB error for undecoded access.
REQ-014 SHALL have port irq_o  output  NumChannels  per-channel level interrupt.

Function
REQ-015 SHALL map channel c at byte offset c*0x10: +0x0 CTRL, +0x4 COUNT, +0x8 COMPARE, +0xC STATUS.
REQ-016 SHALL define CTRL: bit0 EN, bit1 MODE (0 periodic, 1 one-shot), bit2 IRQ_EN, bits[8+PrescWidth-1:8] PRESC; other bits read 0.
REQ-017 SHALL commit a write only in the cycle psel_i & penable_i & pwrite_i; setup phase has no side effects.
REQ-018 SHALL drive prdata_o combinationally from the addressed register when psel_i & ~pwrite_i, zero-extended to 32 bits; 0 otherwise.
REQ-019 SHALL assert pslverr_o during access phase when channel index >= NumChannels or paddr_i[1:0] != 0; erroneous writes change no state, erroneous reads return 0.
REQ-020 SHALL keep a per-channel prescaler counter; while EN=1 it increments each cycle and produces a tick and returns to 0 in the cycle its value equals PRESC (PRESC=0 -> tick every cycle).
REQ-021 SHALL, on a tick, set COUNT to 0 and set STATUS.PEND if COUNT == COMPARE; otherwise increment COUNT modulo 2^CntWidth (all-ones wraps to 0 without setting PEND).
REQ-022 SHALL, in one-shot mode, clear EN in the same cycle PEND is set by a compare match.
REQ-023 SHALL hold COUNT and the prescaler counter while EN=0.
REQ-024 SHALL clear the prescaler counter on any CTRL write that changes EN from 0 to 1.
REQ-025 SHALL give an APB write to COUNT precedence over a same-cycle tick update (written value loaded, no increment, no match evaluated that cycle).
REQ-026 SHALL clear STATUS.PEND by writing 1 to STATUS bit0 (W1C); a same-cycle match set SHALL win over the clear.
REQ-027 SHALL write a CTRL EN=0 with precedence over a same-cycle one-shot auto-clear (result EN=0 either way).
REQ-028 SHALL drive irq_o[c] = PEND[c] & IRQ_EN[c], registered-state-only (no combinational path from APB inputs).
REQ-029 SHALL set PEND one clock after the tick cycle in which COUNT equalled COMPARE; irq_o follows in the same cycle.
REQ-030 SHALL truncate write data to CntWidth for COUNT/COMPARE.

Reset
REQ-031 SHALL, while rst_i=1 at a clock edge, set all CTRL, COUNT, COMPARE, STATUS and prescaler counters to 0.
REQ-032 SHALL drive irq_o=0, prdata_o=0 (absent access), pslverr_o=0 during and after reset; pready_o=1 always.
REQ-033 SHALL abort any in-progress count when reset asserts mid-operation; no PEND survives reset.

Verification
REQ-034 Periodic: ch0 COMPARE=3, PRESC=0, CTRL=0x5 -> COUNT 0,1,2,3,0...; irq_o[0] rises 4 cycles after enable, stays high until STATUS W1C 0x1.
REQ-035 One-shot with prescaler: ch1 COMPARE=2, PRESC=1, CTRL=0x7 -> tick every 2nd cycle; PEND after 6 cycles; CTRL.EN reads 0; COUNT holds 0.
REQ-036 Wrap: CntWidth=8, COUNT=0xFF, COMPARE=0x10, EN=1, PRESC=0 -> next cycle COUNT=0x00, PEND stays 0.
REQ-037 Collisions: COUNT write 0x20 on tick cycle -> COUNT=0x20; W1C on match cycle -> PEND=1.
REQ-038 Errors: NumChannels=4, access 0x40 or 0x06 -> pslverr_o=1, prdata_o=0, no register change.
REQ-039 Reset mid-run: rst_i=1 for 1 cycle while counting with PEND=1 -> all registers read 0, irq_o=0.
